// File: rtl/cv_bg_fetch.sv
// cv_bg_fetch: per-scanline BG tile/char fetch sequencer over the four BG screens
module cv_bg_fetch #(
    parameter int NTILES = 41,
    parameter int CW     = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          line_start,
    input  logic [9:0]    line_num,
    input  logic [3:0]    layer_en,
    input  logic [7:0]    r_rend_order,
    output logic          busy,
    output logic          line_done,
    output logic [1:0]    bg_screen,
    input  logic [9:0]    r_bg_yoffset,
    input  logic [9:0]    r_bg_xoffset,
    input  logic [1:0]    r_bg_bank,
    output logic [13:0]   t_addr,
    output logic          t_ren,
    input  logic [9:0]    t_dout,
    output logic [13:0]   c_addr,
    output logic          c_ren,
    input  logic [63:0]   c_dout,
    output logic          pix_valid,
    output logic [63:0]   pix_data,
    output logic [1:0]    pix_screen,
    output logic [CW-1:0] pix_col,
    output logic [2:0]    pix_fine
);
    typedef enum logic [2:0] {IDLE, SEL, FETCH, DRAIN, DONE} state_t;
    state_t        r_state;
    logic [9:0]    r_line;
    logic [2:0]    r_row;
    logic [2:0]    r_fine;
    logic          r_bank;
    logic          r_drain;
    logic [1:0]    r_slot;
    logic [CW-1:0] r_col;
    logic [1:0]    r_s1_screen;
    logic [CW-1:0] r_s1_col;
    logic [2:0]    r_s1_fine;
    logic [1:0]    w_slot_n;
    logic [1:0]    w_next_screen;
    logic [9:0]    w_y;
    logic          w_last_slot;
    logic          w_unused;

    assign w_slot_n      = r_slot + 2'd1;
    assign w_next_screen = r_rend_order[{w_slot_n, 1'b0} +: 2];
    assign w_y           = r_line + r_bg_yoffset;
    assign w_last_slot   = (r_slot == 2'd3);
    assign c_addr        = c_ren ? {r_bank, t_dout, r_row} : '0;
    assign pix_data      = pix_valid ? c_dout : '0;
    assign w_unused      = r_bg_bank[1];

    // Sequencer FSM plus the two-stage tile->char->pixel pipeline
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_line      <= '0;
            r_row       <= '0;
            r_fine      <= '0;
            r_bank      <= 1'b0;
            r_drain     <= 1'b0;
            r_slot      <= '0;
            r_col       <= '0;
            r_s1_screen <= '0;
            r_s1_col    <= '0;
            r_s1_fine   <= '0;
            busy        <= 1'b0;
            line_done   <= 1'b0;
            bg_screen   <= '0;
            t_addr      <= '0;
            t_ren       <= 1'b0;
            c_ren       <= 1'b0;
            pix_valid   <= 1'b0;
            pix_screen  <= '0;
            pix_col     <= '0;
            pix_fine    <= '0;
        end else begin
            c_ren     <= t_ren;
            pix_valid <= c_ren;
            line_done <= 1'b0;
            if (t_ren) begin
                r_s1_screen <= bg_screen;
                r_s1_col    <= r_col;
                r_s1_fine   <= r_fine;
            end
            if (c_ren) begin
                pix_screen <= r_s1_screen;
                pix_col    <= r_s1_col;
                pix_fine   <= r_s1_fine;
            end
            case (r_state)
                IDLE: begin
                    if (line_start) begin
                        r_line    <= line_num;
                        r_slot    <= '0;
                        bg_screen <= r_rend_order[1:0];
                        busy      <= 1'b1;
                        r_state   <= SEL;
                    end
                end
                SEL: begin
                    if (layer_en[bg_screen]) begin
                        r_row   <= w_y[2:0];
                        r_fine  <= r_bg_xoffset[2:0];
                        r_bank  <= r_bg_bank[0];
                        r_col   <= '0;
                        t_ren   <= 1'b1;
                        t_addr  <= {w_y[9:3], r_bg_xoffset[9:3]};
                        r_state <= FETCH;
                    end else if (w_last_slot) begin
                        line_done <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_slot    <= w_slot_n;
                        bg_screen <= w_next_screen;
                    end
                end
                FETCH: begin
                    if (r_col == CW'(NTILES - 1)) begin
                        t_ren   <= 1'b0;
                        r_drain <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_col  <= r_col + CW'(1);
                        t_addr <= {t_addr[13:7], t_addr[6:0] + 7'd1};
                    end
                end
                DRAIN: begin
                    if (!r_drain) begin
                        r_drain <= 1'b1;
                    end else if (w_last_slot) begin
                        line_done <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_slot    <= w_slot_n;
                        bg_screen <= w_next_screen;
                        r_state   <= SEL;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cv_bg_fetch.sv
// tb_cv_bg_fetch: randomized line fetches checked against a per-cycle schedule model
module tb_cv_bg_fetch;
    localparam int NT = 41;
    localparam int CW = 6;
    localparam int NC = 260;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          line_start = 1'b0;
    logic [9:0]    line_num = '0;
    logic [3:0]    layer_en = '0;
    logic [7:0]    order = '0;
    logic          busy, line_done, t_ren, c_ren, pix_valid;
    logic [1:0]    bg_screen, pix_screen;
    logic [9:0]    r_bg_yoffset, r_bg_xoffset;
    logic [1:0]    r_bg_bank;
    logic [13:0]   t_addr, c_addr;
    logic [9:0]    t_dout = '0;
    logic [63:0]   c_dout = '0;
    logic [63:0]   pix_data;
    logic [CW-1:0] pix_col;
    logic [2:0]    pix_fine;

    logic [9:0] yoff [4];
    logic [9:0] xoff [4];
    logic [1:0] bank [4];
    logic [9:0] tram [16384];

    logic          tv   [NC];
    logic          cs   [NC];
    logic [13:0]   ta   [NC];
    logic [1:0]    ts   [NC];
    logic [CW-1:0] tc   [NC];
    logic [2:0]    tf   [NC];
    logic [2:0]    trow [NC];
    logic          tbk  [NC];

    int n_checks = 0;
    int n_errors = 0;

    cv_bg_fetch #(.NTILES(NT), .CW(CW)) dut (
        .clk(clk), .reset(reset), .line_start(line_start), .line_num(line_num),
        .layer_en(layer_en), .r_rend_order(order), .busy(busy), .line_done(line_done),
        .bg_screen(bg_screen), .r_bg_yoffset(r_bg_yoffset), .r_bg_xoffset(r_bg_xoffset),
        .r_bg_bank(r_bg_bank), .t_addr(t_addr), .t_ren(t_ren), .t_dout(t_dout),
        .c_addr(c_addr), .c_ren(c_ren), .c_dout(c_dout), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_screen(pix_screen), .pix_col(pix_col), .pix_fine(pix_fine)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] cmem(input logic [13:0] a);
        return (64'(a) * 64'h9E37_79B9_7F4A_7C15) ^ 64'(a);
    endfunction

    // Scroll registers muxed by bg_screen; scrambled while fetching so late sampling shows up
    always_comb begin
        r_bg_yoffset = t_ren ? ~yoff[bg_screen] : yoff[bg_screen];
        r_bg_xoffset = t_ren ? ~xoff[bg_screen] : xoff[bg_screen];
        r_bg_bank    = t_ren ? ~bank[bg_screen] : bank[bg_screen];
    end

    // Synchronous tile and char memories
    always @(posedge clk) begin
        if (t_ren) t_dout <= tram[t_addr];
        if (c_ren) c_dout <= cmem(c_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, 64'({busy, line_done, t_ren, c_ren, pix_valid, bg_screen, t_addr,
                        c_addr, pix_screen, pix_col, pix_fine}), 64'd0);
        check({tag, "_pix_data"}, pix_data, 64'd0);
    endtask

    task automatic run_line(input logic [9:0] ln, input int extra_at, input int abort_at);
        int c, d, last;
        logic [9:0] y;
        logic [1:0] scr;
        logic [13:0] ca;
        for (int i = 0; i < NC; i++) begin
            tv[i] = 1'b0;
            cs[i] = 1'b0;
        end
        c = 1;
        for (int s = 0; s < 4; s++) begin
            scr   = order[2*s +: 2];
            cs[c] = 1'b1;
            ts[c] = scr;
            if (layer_en[scr]) begin
                y = ln + yoff[scr];
                for (int k = 0; k < NT + 2; k++) begin
                    cs[c+1+k] = 1'b1;
                    ts[c+1+k] = scr;
                end
                for (int k = 0; k < NT; k++) begin
                    tv[c+1+k]   = 1'b1;
                    ta[c+1+k]   = {y[9:3], 7'((xoff[scr] >> 3) + 10'(k))};
                    tc[c+1+k]   = CW'(k);
                    tf[c+1+k]   = xoff[scr][2:0];
                    trow[c+1+k] = y[2:0];
                    tbk[c+1+k]  = bank[scr][0];
                end
                c += NT + 3;
            end else begin
                c++;
            end
        end
        d = c;
        last = (abort_at > 0) ? abort_at : d + 2;
        @(negedge clk);
        line_start = 1'b1;
        line_num   = ln;
        for (c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) begin
                line_start = 1'b0;
                line_num   = 10'($urandom);
            end
            check("busy", 64'(busy), 64'(c <= d));
            check("line_done", 64'(line_done), 64'(c == d));
            check("t_ren", 64'(t_ren), 64'(tv[c]));
            if (tv[c]) check("t_addr", 64'(t_addr), 64'(ta[c]));
            if (cs[c]) check("bg_screen", 64'(bg_screen), 64'(ts[c]));
            check("c_ren", 64'(c_ren), 64'(tv[c-1]));
            if (tv[c-1]) begin
                ca = {tbk[c-1], tram[ta[c-1]], trow[c-1]};
                check("c_addr", 64'(c_addr), 64'(ca));
                if (ta[c-1] == 14'h0005 && tbk[c-1] && trow[c-1] == 3'd3 && tram[14'h0005] == 10'h3A5)
                    check("c_addr_3d2b", 64'(c_addr), 64'h3D2B);
            end
            if (c >= 2) begin
                check("pix_valid", 64'(pix_valid), 64'(tv[c-2]));
                if (tv[c-2]) begin
                    ca = {tbk[c-2], tram[ta[c-2]], trow[c-2]};
                    check("pix_data", pix_data, cmem(ca));
                    check("pix_screen", 64'(pix_screen), 64'(ts[c-2]));
                    check("pix_col", 64'(pix_col), 64'(tc[c-2]));
                    check("pix_fine", 64'(pix_fine), 64'(tf[c-2]));
                end
            end
            if (c == extra_at) line_start = 1'b1;
            if (c == extra_at + 1) line_start = 1'b0;
            if (c == abort_at) reset = 1'b0;
        end
        if (abort_at > 0) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_zero("abort");
            end
            reset = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("abort_idle", 64'({busy, line_done}), 64'd0);
            end
        end
    endtask

    task automatic randomize_regs();
        for (int i = 0; i < 4; i++) begin
            yoff[i] = 10'($urandom);
            xoff[i] = 10'($urandom);
            bank[i] = 2'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) tram[i] = 10'($urandom);
        for (int i = 0; i < 4; i++) begin
            yoff[i] = '0;
            xoff[i] = '0;
            bank[i] = '0;
        end
        order    = 8'hE4;
        layer_en = 4'hF;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        run_line(10'd0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            yoff[i] = 10'd10;
            xoff[i] = 10'd1021;
        end
        run_line(10'd1020, 0, 0);
        layer_en = 4'b0000;
        run_line(10'd5, 0, 0);
        layer_en = 4'b0100;
        run_line(10'd77, 0, 0);
        layer_en = 4'b0001;
        yoff[0]  = '0;
        xoff[0]  = '0;
        bank[0]  = 2'b01;
        tram[14'h0005] = 10'h3A5;
        run_line(10'd3, 0, 0);
        layer_en = 4'hF;
        randomize_regs();
        run_line(10'($urandom), 50, 0);
        run_line(10'd100, 0, 30);
        run_line(10'd200, 0, 0);
        order    = 8'h00;
        layer_en = 4'b0001;
        run_line(10'($urandom), 0, 0);
        for (int n = 0; n < 10; n++) begin
            randomize_regs();
            order    = 8'($urandom);
            layer_en = 4'($urandom);
            run_line(10'($urandom), int'($urandom_range(0, 120)), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
